cdp_responder: RTL and testbench

Core-side end of the Core Debug Port command channel. It accepts decoded CDP commands (write/read, 3-bit op, 32-bit data) issued on Update-DR and maintains the SELECT, TADDR and DTR debug registers. DTR accesses become single-beat transactions on the core debug memory bus. It returns a 32-bit result and a 4-bit ACK, which the CDP loads into its scan chain at the next Capture-DR.

---
 rtl/cdp_pkg.sv | 28 ++
 rtl/cdp_bus_access.sv | 74 +++++++
 rtl/cdp_responder.sv | 174 +++++++++++++++++
 tb/tb_cdp_responder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/cdp_pkg.sv
// cdp_pkg: shared constants for the Core Debug Port command channel.
// Holds the op encodings and ACK codes (also used by the JTAG-side port),
// the STATUS bit positions and the bus-access FSM state type.
package cdp_pkg;

    // Register select encodings carried in cmd_op
    localparam logic [2:0] CDP_SELECT = 3'b000;
    localparam logic [2:0] CDP_TADDR  = 3'b001;
    localparam logic [2:0] CDP_DTR    = 3'b010;
    localparam logic [2:0] CDP_STATUS = 3'b011;

    // ACK codes returned with every response
    localparam logic [3:0] ACK_OK    = 4'b0010;
    localparam logic [3:0] ACK_WAIT  = 4'b0001;
    localparam logic [3:0] ACK_FAULT = 4'b0100;

    // STATUS bit positions; [2:0] are sticky, [3] is live
    localparam int ST_BUSERR  = 0;
    localparam int ST_TIMEOUT = 1;
    localparam int ST_OVERRUN = 2;
    localparam int ST_BUSY    = 3;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } cdp_state_e;

endpackage

// File: rtl/cdp_bus_access.sv
// cdp_bus_access: single-beat bus access sequencer with timeout.
// Ports:
//   clk, rst_n   - clock, synchronous active-low reset
//   start_i      - begin an access (only honoured in IDLE)
//   bus_ack_i    - target completed the access
//   bus_err_i    - target reported an error (wins over bus_ack_i)
//   active_o     - access in flight (drives bus_req / busy)
//   done_o       - completing OK on this edge
//   err_o        - completing with a bus error on this edge
//   timeout_o    - aborting on timeout at this edge
module cdp_bus_access
    import cdp_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic bus_ack_i,
    input  logic bus_err_i,
    output logic active_o,
    output logic done_o,
    output logic err_o,
    output logic timeout_o
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    cdp_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = '0;
        active_o  = 1'b0;
        done_o    = 1'b0;
        err_o     = 1'b0;
        timeout_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = ACCESS;
            end
            ACCESS: begin
                active_o = 1'b1;
                // A response on the last counted cycle still beats the timeout.
                if (bus_err_i) begin
                    err_o   = 1'b1;
                    state_d = IDLE;
                end else if (bus_ack_i) begin
                    done_o  = 1'b1;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    timeout_o = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/cdp_responder.sv
// cdp_responder: core-side end of the CDP command channel.
// Decodes commands issued on Update-DR, holds SELECT/TADDR/DTR/STATUS,
// turns DTR accesses into single-beat bus transactions and produces the
// result/ACK pair captured by the CDP at the next Capture-DR.
// Ports:
//   tck, trst_n                 - clock, synchronous active-low reset
//   cmd_valid/wr/op/data        - one-cycle decoded command
//   rsp_result, rsp_ack         - response of the last completed command
//   busy                        - bus access in flight
//   bus_req/we/addr/wdata       - debug memory bus request side
//   bus_ack, bus_rdata, bus_err - debug memory bus response side
module cdp_responder
    import cdp_pkg::*;
#(
    parameter int          TIMEOUT  = 255,
    parameter logic [31:0] ADDR_INC = 32'd4
) (
    input  logic        tck,
    input  logic        trst_n,
    input  logic        cmd_valid,
    input  logic        cmd_wr,
    input  logic [2:0]  cmd_op,
    input  logic [31:0] cmd_data,
    output logic [31:0] rsp_result,
    output logic [3:0]  rsp_ack,
    output logic        busy,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
    input  logic        bus_err
);

    logic        sel_q, sel_d;
    logic [31:0] taddr_q, taddr_d;
    logic [31:0] dtr_q, dtr_d;
    logic [2:0]  status_q, status_d;
    logic [31:0] result_q, result_d;
    logic [3:0]  ack_q, ack_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic start, acc_active, acc_done, acc_err, acc_tmo;

    cdp_bus_access #(.TIMEOUT(TIMEOUT)) u_access (
        .clk       (tck),
        .rst_n     (trst_n),
        .start_i   (start),
        .bus_ack_i (bus_ack),
        .bus_err_i (bus_err),
        .active_o  (acc_active),
        .done_o    (acc_done),
        .err_o     (acc_err),
        .timeout_o (acc_tmo)
    );

    always_ff @(posedge tck) begin
        if (!trst_n) begin
            sel_q    <= 1'b0;
            taddr_q  <= '0;
            dtr_q    <= '0;
            status_q <= '0;
            result_q <= '0;
            ack_q    <= ACK_OK;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            sel_q    <= sel_d;
            taddr_q  <= taddr_d;
            dtr_q    <= dtr_d;
            status_q <= status_d;
            result_q <= result_d;
            ack_q    <= ack_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    always_comb begin
        sel_d    = sel_q;
        taddr_d  = taddr_q;
        dtr_d    = dtr_q;
        status_d = status_q;
        result_d = result_q;
        ack_d    = ack_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        start    = 1'b0;

        if (acc_active) begin
            // Commands arriving mid-access are dropped; the response stays WAIT.
            if (cmd_valid) status_d[ST_OVERRUN] = 1'b1;
            if (acc_err) begin
                ack_d                = ACK_FAULT;
                result_d             = '0;
                status_d[ST_BUSERR]  = 1'b1;
            end else if (acc_done) begin
                ack_d = ACK_OK;
                if (we_q) begin
                    result_d = dtr_q;
                end else begin
                    dtr_d    = bus_rdata;
                    result_d = bus_rdata;
                end
                if (sel_q) taddr_d = taddr_q + ADDR_INC;
            end else if (acc_tmo) begin
                ack_d                = ACK_FAULT;
                result_d             = '0;
                status_d[ST_TIMEOUT] = 1'b1;
            end
        end else if (cmd_valid) begin
            ack_d = ACK_OK;
            case (cmd_op)
                CDP_SELECT: begin
                    if (cmd_wr) begin
                        sel_d    = cmd_data[0];
                        result_d = cmd_data;
                    end else begin
                        result_d = {31'b0, sel_q};
                    end
                end
                CDP_TADDR: begin
                    if (cmd_wr) begin
                        taddr_d  = cmd_data;
                        result_d = cmd_data;
                    end else begin
                        result_d = taddr_q;
                    end
                end
                CDP_STATUS: begin
                    if (cmd_wr) begin
                        status_d = status_q & ~cmd_data[2:0];
                        result_d = cmd_data;
                    end else begin
                        result_d = {28'b0, acc_active, status_q};
                    end
                end
                CDP_DTR: begin
                    // A pending bus error or timeout blocks further bus traffic.
                    if (status_q[ST_TIMEOUT] || status_q[ST_BUSERR]) begin
                        ack_d    = ACK_FAULT;
                        result_d = '0;
                    end else begin
                        start   = 1'b1;
                        ack_d   = ACK_WAIT;
                        we_d    = cmd_wr;
                        addr_d  = taddr_q;
                        wdata_d = cmd_data;
                        if (cmd_wr) dtr_d = cmd_data;
                    end
                end
                default: begin
                    ack_d    = ACK_FAULT;
                    result_d = '0;
                end
            endcase
        end
    end

    assign rsp_result = result_q;
    assign rsp_ack    = ack_q;
    assign busy       = acc_active;
    assign bus_req    = acc_active;
    assign bus_we     = we_q;
    assign bus_addr   = addr_q;
    assign bus_wdata  = wdata_q;

endmodule

// File: tb/tb_cdp_responder.sv
// tb_cdp_responder: directed self-checking bench for cdp_responder.
// Inputs change and outputs are sampled on the falling edge of tck.
module tb_cdp_responder;
    import cdp_pkg::*;

    logic        tck = 1'b0;
    logic        trst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_wr = 1'b0;
    logic [2:0]  cmd_op = 3'b0;
    logic [31:0] cmd_data = '0;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_ack;
    logic        busy, bus_req, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        bus_err = 1'b0;

    int checks = 0;
    int failures = 0;
    int n;

    cdp_responder #(.TIMEOUT(8), .ADDR_INC(32'd4)) dut (
        .tck(tck), .trst_n(trst_n),
        .cmd_valid(cmd_valid), .cmd_wr(cmd_wr), .cmd_op(cmd_op), .cmd_data(cmd_data),
        .rsp_result(rsp_result), .rsp_ack(rsp_ack), .busy(busy),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
    );

    always #5 tck = ~tck;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one command; returns on the falling edge after it was taken.
    task automatic cmd(input logic wr, input logic [2:0] op, input logic [31:0] data);
        @(negedge tck);
        cmd_valid = 1'b1; cmd_wr = wr; cmd_op = op; cmd_data = data;
        @(negedge tck);
        cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_op = 3'b0; cmd_data = '0;
    endtask

    initial begin
        // Reset
        repeat (2) @(negedge tck);
        chk("rst_ack", {28'b0, rsp_ack}, {28'b0, ACK_OK});
        chk("rst_result", rsp_result, 32'h0);
        chk("rst_req", {31'b0, bus_req}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_addr", bus_addr, 32'h0);
        trst_n = 1'b1;

        // TADDR write / read
        cmd(1'b1, CDP_TADDR, 32'h1000);
        chk("taddr_wr_res", rsp_result, 32'h1000);
        chk("taddr_wr_ack", {28'b0, rsp_ack}, {28'b0, ACK_OK});
        cmd(1'b0, CDP_TADDR, 32'h0);
        chk("taddr_rd_res", rsp_result, 32'h1000);
        chk("taddr_rd_ack", {28'b0, rsp_ack}, {28'b0, ACK_OK});

        // Invalid op
        cmd(1'b1, 3'b101, 32'h1234);
        chk("inval_ack", {28'b0, rsp_ack}, {28'b0, ACK_FAULT});
        chk("inval_res", rsp_result, 32'h0);

        // SELECT=1, DTR write acked on the third bus_req cycle
        cmd(1'b1, CDP_SELECT, 32'h1);
        chk("sel_wr_res", rsp_result, 32'h1);
        cmd(1'b0, CDP_SELECT, 32'h0);
        chk("sel_rd_res", rsp_result, 32'h1);
        cmd(1'b1, CDP_DTR, 32'hDEADBEEF);
        chk("dtrw_req", {31'b0, bus_req}, 32'h1);
        chk("dtrw_busy", {31'b0, busy}, 32'h1);
        chk("dtrw_ack_wait", {28'b0, rsp_ack}, {28'b0, ACK_WAIT});
        chk("dtrw_addr", bus_addr, 32'h1000);
        chk("dtrw_we", {31'b0, bus_we}, 32'h1);
        chk("dtrw_wdata", bus_wdata, 32'hDEADBEEF);
        repeat (2) @(negedge tck);
        chk("dtrw_addr_stable", bus_addr, 32'h1000);
        bus_ack = 1'b1;
        @(negedge tck);
        bus_ack = 1'b0;
        chk("dtrw_req_drop", {31'b0, bus_req}, 32'h0);
        chk("dtrw_ack_ok", {28'b0, rsp_ack}, {28'b0, ACK_OK});
        chk("dtrw_res", rsp_result, 32'hDEADBEEF);
        cmd(1'b0, CDP_TADDR, 32'h0);
        chk("taddr_inc", rsp_result, 32'h1004);

        // DTR read with wrap of TADDR
        cmd(1'b1, CDP_TADDR, 32'hFFFFFFFC);
        cmd(1'b0, CDP_DTR, 32'h0);
        chk("dtrr_we", {31'b0, bus_we}, 32'h0);
        chk("dtrr_addr", bus_addr, 32'hFFFFFFFC);
        bus_rdata = 32'h12345678; bus_ack = 1'b1;
        @(negedge tck);
        bus_ack = 1'b0;
        chk("dtrr_res", rsp_result, 32'h12345678);
        chk("dtrr_ack", {28'b0, rsp_ack}, {28'b0, ACK_OK});
        cmd(1'b0, CDP_TADDR, 32'h0);
        chk("taddr_wrap", rsp_result, 32'h0);

        // bus_err and bus_ack together: error wins, sticky fault
        cmd(1'b0, CDP_DTR, 32'h0);
        bus_err = 1'b1; bus_ack = 1'b1; bus_rdata = 32'hCAFEF00D;
        @(negedge tck);
        bus_err = 1'b0; bus_ack = 1'b0;
        chk("err_ack", {28'b0, rsp_ack}, {28'b0, ACK_FAULT});
        chk("err_res", rsp_result, 32'h0);
        cmd(1'b0, CDP_TADDR, 32'h0);
        chk("err_taddr", rsp_result, 32'h0);
        cmd(1'b0, CDP_STATUS, 32'h0);
        chk("err_status", rsp_result, 32'h1);
        cmd(1'b0, CDP_DTR, 32'h0);
        chk("sticky_noreq", {31'b0, bus_req}, 32'h0);
        chk("sticky_ack", {28'b0, rsp_ack}, {28'b0, ACK_FAULT});
        cmd(1'b1, CDP_STATUS, 32'h7);
        cmd(1'b0, CDP_STATUS, 32'h0);
        chk("status_clr", rsp_result, 32'h0);
        cmd(1'b0, CDP_DTR, 32'h0);
        chk("after_clr_req", {31'b0, bus_req}, 32'h1);
        bus_rdata = 32'hA5A5A5A5; bus_ack = 1'b1;
        @(negedge tck);
        bus_ack = 1'b0;
        chk("after_clr_res", rsp_result, 32'hA5A5A5A5);
        chk("after_clr_ack", {28'b0, rsp_ack}, {28'b0, ACK_OK});

        // Timeout with a dropped command mid-access (TADDR is 4 now)
        cmd(1'b0, CDP_DTR, 32'h0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus_req) n++;
            else break;
            if (i == 2) begin
                cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_op = CDP_TADDR; cmd_data = 32'h5555;
            end else begin
                cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_op = 3'b0; cmd_data = '0;
            end
            if (i == 3) chk("ovr_ack_wait", {28'b0, rsp_ack}, {28'b0, ACK_WAIT});
            @(negedge tck);
        end
        chk("tmo_req_cycles", n, 32'd8);
        chk("tmo_ack", {28'b0, rsp_ack}, {28'b0, ACK_FAULT});
        chk("tmo_res", rsp_result, 32'h0);
        cmd(1'b0, CDP_STATUS, 32'h0);
        chk("tmo_status", rsp_result, 32'h6);
        cmd(1'b0, CDP_TADDR, 32'h0);
        chk("ovr_dropped", rsp_result, 32'h4);

        // Reset mid-access
        cmd(1'b1, CDP_STATUS, 32'h7);
        cmd(1'b1, CDP_TADDR, 32'h40);
        cmd(1'b1, CDP_DTR, 32'h77);
        chk("mid_req", {31'b0, bus_req}, 32'h1);
        trst_n = 1'b0;
        @(negedge tck);
        chk("mid_rst_req", {31'b0, bus_req}, 32'h0);
        chk("mid_rst_busy", {31'b0, busy}, 32'h0);
        chk("mid_rst_ack", {28'b0, rsp_ack}, {28'b0, ACK_OK});
        chk("mid_rst_res", rsp_result, 32'h0);
        chk("mid_rst_addr", bus_addr, 32'h0);
        chk("mid_rst_wdata", bus_wdata, 32'h0);
        chk("mid_rst_we", {31'b0, bus_we}, 32'h0);
        trst_n = 1'b1;
        cmd(1'b0, CDP_TADDR, 32'h0);
        chk("post_rst_taddr", rsp_result, 32'h0);
        cmd(1'b0, CDP_DTR, 32'h0);
        chk("post_rst_dtr_req", {31'b0, bus_req}, 32'h1);
        bus_rdata = 32'h0BADF00D; bus_ack = 1'b1;
        @(negedge tck);
        bus_ack = 1'b0;
        chk("post_rst_dtr_res", rsp_result, 32'h0BADF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
